// File: rtl/da2_frame_rx.sv
// da2_frame_rx: oversampled receiver for the PmodDA2 serial link.
// Rebuilds both DAC121S101 frames from SYNC/SCLK/SDATA in the clk domain.
module da2_frame_rx #(
   parameter int FRAME_W     = 16,
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SYNC,
   input  logic              SCLK,
   input  logic [1:0]        SDATA,
   output logic [DATA_W-1:0] value0,
   output logic [DATA_W-1:0] value1,
   output logic [1:0]        pd0,
   output logic [1:0]        pd1,
   output logic              valid,
   output logic              frame_err,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int BC_W = $clog2(FRAME_W + 1);
   // Only DB13..DB0 are kept; DB15:14 fall off the top.
   localparam int SH_W = DATA_W + 2;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT
   } state_t;

   logic [SYNC_STAGES-1:0] sync_sr_q, sync_sr_d;
   logic [SYNC_STAGES-1:0] sclk_sr_q, sclk_sr_d;
   logic [SYNC_STAGES-1:0] sd0_sr_q, sd0_sr_d;
   logic [SYNC_STAGES-1:0] sd1_sr_q, sd1_sr_d;
   logic                   sclk_prev_q, sclk_prev_d;

   state_t            state_q, state_d;
   logic [SH_W-1:0]   sh0_q, sh0_d;
   logic [SH_W-1:0]   sh1_q, sh1_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] value0_q, value0_d;
   logic [DATA_W-1:0] value1_q, value1_d;
   logic [1:0]        pd0_q, pd0_d;
   logic [1:0]        pd1_q, pd1_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic       sync_s;
   logic       sclk_s;
   logic [1:0] sd_s;
   logic       fall;

   assign sync_s = sync_sr_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sr_q[SYNC_STAGES-1];
   assign sd_s   = {sd1_sr_q[SYNC_STAGES-1], sd0_sr_q[SYNC_STAGES-1]};
   assign fall   = sclk_prev_q & ~sclk_s;

   // Synchroniser chains and SCLK edge history.
   always_comb begin
      sync_sr_d   = {sync_sr_q[SYNC_STAGES-2:0], SYNC};
      sclk_sr_d   = {sclk_sr_q[SYNC_STAGES-2:0], SCLK};
      sd0_sr_d    = {sd0_sr_q[SYNC_STAGES-2:0], SDATA[0]};
      sd1_sr_d    = {sd1_sr_q[SYNC_STAGES-2:0], SDATA[1]};
      sclk_prev_d = sclk_s;
   end

   // Frame FSM: shift on falling edges, commit one cycle after the last bit.
   always_comb begin
      state_d   = state_q;
      sh0_d     = sh0_q;
      sh1_d     = sh1_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      value0_d  = value0_q;
      value1_d  = value1_q;
      pd0_d     = pd0_q;
      pd1_d     = pd1_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      cnt_d     = cnt_q;

      if (done_q) begin
         value0_d = sh0_q[DATA_W-1:0];
         value1_d = sh1_q[DATA_W-1:0];
         pd0_d    = sh0_q[SH_W-1:DATA_W];
         pd1_d    = sh1_q[SH_W-1:DATA_W];
         valid_d  = 1'b1;
         cnt_d    = cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (!sync_s) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (fall) begin
               sh0_d     = {sh0_q[SH_W-2:0], sd_s[0]};
               sh1_d     = {sh1_q[SH_W-2:0], sd_s[1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               // The last edge wins over a coincident SYNC rise.
               if (bit_cnt_q == BC_W'(FRAME_W - 1)) begin
                  done_d  = 1'b1;
                  state_d = sync_s ? IDLE : WAIT;
               end else if (sync_s) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (sync_s) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (sync_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_sr_q   <= '1;
         sclk_sr_q   <= '0;
         sd0_sr_q    <= '0;
         sd1_sr_q    <= '0;
         sclk_prev_q <= 1'b0;
         state_q     <= IDLE;
         sh0_q       <= '0;
         sh1_q       <= '0;
         bit_cnt_q   <= '0;
         done_q      <= 1'b0;
         value0_q    <= '0;
         value1_q    <= '0;
         pd0_q       <= '0;
         pd1_q       <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync_sr_q   <= sync_sr_d;
         sclk_sr_q   <= sclk_sr_d;
         sd0_sr_q    <= sd0_sr_d;
         sd1_sr_q    <= sd1_sr_d;
         sclk_prev_q <= sclk_prev_d;
         state_q     <= state_d;
         sh0_q       <= sh0_d;
         sh1_q       <= sh1_d;
         bit_cnt_q   <= bit_cnt_d;
         done_q      <= done_d;
         value0_q    <= value0_d;
         value1_q    <= value1_d;
         pd0_q       <= pd0_d;
         pd1_q       <= pd1_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign value0    = value0_q;
   assign value1    = value1_q;
   assign pd0       = pd0_q;
   assign pd1       = pd1_q;
   assign valid     = valid_q;
   assign frame_err = err_q;
   assign busy      = (state_q != IDLE);
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_da2_frame_rx.sv
// tb_da2_frame_rx: drives PmodDA2-style frames into da2_frame_rx
// and compares against a frame-level reference model.
module tb_da2_frame_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        SYNC;
   logic        SCLK;
   logic [1:0]  SDATA;
   logic [11:0] value0;
   logic [11:0] value1;
   logic [1:0]  pd0;
   logic [1:0]  pd1;
   logic        valid;
   logic        frame_err;
   logic        busy;
   logic [15:0] frame_cnt;

   int vectors = 0;
   int miscompares = 0;

   int valid_seen = 0;
   int err_seen = 0;
   int both_seen = 0;

   logic [11:0] exp_v0, exp_v1;
   logic [1:0]  exp_pd0, exp_pd1;
   logic [15:0] exp_cnt;
   int          exp_valid = 0;
   int          exp_err = 0;

   da2_frame_rx dut (
      .clk       (clk),
      .rst       (rst),
      .SYNC      (SYNC),
      .SCLK      (SCLK),
      .SDATA     (SDATA),
      .value0    (value0),
      .value1    (value1),
      .pd0       (pd0),
      .pd1       (pd1),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) valid_seen++;
         if (frame_err) err_seen++;
         if (valid && frame_err) both_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference: a frame is good iff at least 16 falling edges arrive
   // while SYNC is low; the first 16 bits, MSB first, form the word.
   task automatic model_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input int nbits);
      if (nbits >= 16) begin
         exp_v0  = w0[11:0];
         exp_v1  = w1[11:0];
         exp_pd0 = w0[13:12];
         exp_pd1 = w1[13:12];
         exp_cnt = exp_cnt + 16'd1;
         exp_valid++;
      end else begin
         exp_err++;
      end
   endtask

   task automatic model_reset();
      exp_v0  = '0;
      exp_v1  = '0;
      exp_pd0 = '0;
      exp_pd1 = '0;
      exp_cnt = '0;
   endtask

   // Clock out nbits with SYNC already low; SCLK half period 3 clk.
   task automatic drive_bits(input logic [15:0] w0, input logic [15:0] w1,
                             input int nbits, input bit sync_last);
      logic [1:0] b;
      for (int i = 0; i < nbits; i++) begin
         if (i < 16) begin
            b = {w1[15-i], w0[15-i]};
         end else begin
            b = 2'($urandom);
         end
         SDATA = b;
         SCLK  = 1'b1;
         tick(3);
         SCLK = 1'b0;
         if (sync_last && i == nbits - 1) SYNC = 1'b1;
         tick(3);
      end
      SCLK = 1'b1;
   endtask

   task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                             input int nbits, input bit sync_last);
      SYNC = 1'b0;
      tick(3);
      drive_bits(w0, w1, nbits, sync_last);
      tick(2);
      SYNC = 1'b1;
      tick(8);
      model_frame(w0, w1, nbits);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      SYNC  = 1'b1;
      SCLK  = 1'b1;
      SDATA = 2'b00;
      model_reset();
      tick(3);
      vectors++;
      if ({value0, value1, pd0, pd1, valid, frame_err, busy, frame_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v0=%h v1=%h pd0=%b pd1=%b vld=%b err=%b busy=%b cnt=%0d, want all 0",
                  value0, value1, pd0, pd1, valid, frame_err, busy, frame_cnt);
      end
      rst = 1'b0;
      tick(4);
      vectors++;
      if ({valid, frame_err, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_release: got vld=%b err=%b busy=%b, want 000",
                  valid, frame_err, busy);
      end
   endtask

   task automatic test_basic();
      int v = valid_seen;
      send_frame(16'h0AAA, 16'h0FFF, 16, 1'b0);
      vectors++;
      if (valid_seen - v !== 1) begin
         miscompares++;
         $display("FAIL basic_valid: got %0d pulses, want 1", valid_seen - v);
      end
      vectors++;
      if ({value0, value1, pd0, pd1, frame_cnt} !== {12'hAAA, 12'hFFF, 2'b00, 2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL basic_data: got v0=%h v1=%h pd0=%b pd1=%b cnt=%0d, want AAA FFF 00 00 1",
                  value0, value1, pd0, pd1, frame_cnt);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_busy: got %b, want 0", busy);
      end
   endtask

   task automatic test_pd();
      send_frame(16'hD123, 16'hD123, 16, 1'b0);
      vectors++;
      if ({value0, value1, pd0, pd1} !== {12'h123, 12'h123, 2'b01, 2'b01}) begin
         miscompares++;
         $display("FAIL pd_bits: got v0=%h v1=%h pd0=%b pd1=%b, want 123 123 01 01",
                  value0, value1, pd0, pd1);
      end
      vectors++;
      if (frame_cnt !== exp_cnt) begin
         miscompares++;
         $display("FAIL pd_cnt: got %0d, want %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_abort();
      int v = valid_seen;
      int e = err_seen;
      logic [15:0] w = 16'($urandom);
      send_frame(w, ~w, 8, 1'b0);
      vectors++;
      if ((valid_seen - v) !== 0 || (err_seen - e) !== 1) begin
         miscompares++;
         $display("FAIL abort_pulses: got valid=%0d err=%0d, want 0 1",
                  valid_seen - v, err_seen - e);
      end
      vectors++;
      if ({value0, value1, pd0, pd1, frame_cnt} !== {exp_v0, exp_v1, exp_pd0, exp_pd1, exp_cnt}) begin
         miscompares++;
         $display("FAIL abort_hold: got v0=%h v1=%h cnt=%0d, want v0=%h v1=%h cnt=%0d",
                  value0, value1, frame_cnt, exp_v0, exp_v1, exp_cnt);
      end
   endtask

   task automatic test_overrun();
      int v = valid_seen;
      int e = err_seen;
      send_frame(16'h05A5, 16'($urandom), 20, 1'b0);
      vectors++;
      if ((valid_seen - v) !== 1 || (err_seen - e) !== 0) begin
         miscompares++;
         $display("FAIL overrun_pulses: got valid=%0d err=%0d, want 1 0",
                  valid_seen - v, err_seen - e);
      end
      vectors++;
      if ({value0, value1, pd1, frame_cnt} !== {12'h5A5, exp_v1, exp_pd1, exp_cnt}) begin
         miscompares++;
         $display("FAIL overrun_data: got v0=%h v1=%h cnt=%0d, want 5A5 %h %0d",
                  value0, value1, frame_cnt, exp_v1, exp_cnt);
      end
   endtask

   task automatic test_simultaneous();
      int v = valid_seen;
      int e = err_seen;
      send_frame(16'h2C3D, 16'h1E4F, 16, 1'b1);
      vectors++;
      if ((valid_seen - v) !== 1 || (err_seen - e) !== 0) begin
         miscompares++;
         $display("FAIL simul_pulses: got valid=%0d err=%0d, want 1 0",
                  valid_seen - v, err_seen - e);
      end
      vectors++;
      if ({value0, value1, pd0, pd1, busy} !== {12'hC3D, 12'hE4F, 2'b10, 2'b01, 1'b0}) begin
         miscompares++;
         $display("FAIL simul_data: got v0=%h v1=%h pd0=%b pd1=%b busy=%b, want C3D E4F 10 01 0",
                  value0, value1, pd0, pd1, busy);
      end
   endtask

   task automatic test_reset_midframe();
      int v = valid_seen;
      int e = err_seen;
      SYNC = 1'b0;
      tick(3);
      drive_bits(16'h0777, 16'h0888, 10, 1'b0);
      rst = 1'b1;
      tick(2);
      SYNC = 1'b1;
      SCLK = 1'b1;
      model_reset();
      tick(2);
      rst = 1'b0;
      tick(6);
      vectors++;
      if ((valid_seen - v) !== 0 || (err_seen - e) !== 0 || frame_cnt !== 16'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_quiet: got valid=%0d err=%0d cnt=%0d busy=%b, want 0 0 0 0",
                  valid_seen - v, err_seen - e, frame_cnt, busy);
      end
      send_frame(16'h00F0, 16'h00F0, 16, 1'b0);
      vectors++;
      if ({value0, value1, frame_cnt} !== {12'h0F0, 12'h0F0, 16'd1}) begin
         miscompares++;
         $display("FAIL midreset_next: got v0=%h v1=%h cnt=%0d, want 0F0 0F0 1",
                  value0, value1, frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int v = valid_seen;
      logic [15:0] c = frame_cnt;
      logic [11:0] a0 = 12'($urandom);
      logic [11:0] a1 = 12'($urandom);
      logic [11:0] b0 = 12'($urandom);
      logic [11:0] b1 = 12'($urandom);
      int saw_first = 0;
      SYNC = 1'b0;
      tick(3);
      drive_bits({4'b0000, a0}, {4'b0000, a1}, 16, 1'b0);
      tick(2);
      SYNC = 1'b1;
      tick(3);
      if (value0 === a0 && value1 === a1) saw_first = 1;
      SYNC = 1'b0;
      tick(3);
      drive_bits({4'b0000, b0}, {4'b0000, b1}, 16, 1'b0);
      tick(2);
      SYNC = 1'b1;
      tick(8);
      model_frame({4'b0000, a0}, {4'b0000, a1}, 16);
      model_frame({4'b0000, b0}, {4'b0000, b1}, 16);
      vectors++;
      if ((valid_seen - v) !== 2 || (frame_cnt - c) !== 16'd2) begin
         miscompares++;
         $display("FAIL b2b_count: got valid=%0d cnt_delta=%0d, want 2 2",
                  valid_seen - v, frame_cnt - c);
      end
      vectors++;
      if (saw_first !== 1) begin
         miscompares++;
         $display("FAIL b2b_first: got v0=%h v1=%h after frame 1, want %h %h",
                  value0, value1, a0, a1);
      end
      vectors++;
      if ({value0, value1, pd0, pd1} !== {b0, b1, 4'b0000}) begin
         miscompares++;
         $display("FAIL b2b_second: got v0=%h v1=%h, want %h %h",
                  value0, value1, b0, b1);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         logic [15:0] w0 = 16'($urandom);
         logic [15:0] w1 = 16'($urandom);
         int sel = $urandom_range(0, 3);
         int n = (sel == 0) ? $urandom_range(1, 15) :
                 (sel == 3) ? $urandom_range(17, 24) : 16;
         bit sl = 1'($urandom);
         send_frame(w0, w1, n, sl);
         vectors++;
         if ({value0, value1, pd0, pd1, frame_cnt} !== {exp_v0, exp_v1, exp_pd0, exp_pd1, exp_cnt}) begin
            miscompares++;
            $display("FAIL random_%0d n=%0d: got v0=%h v1=%h pd0=%b pd1=%b cnt=%0d, want %h %h %b %b %0d",
                     k, n, value0, value1, pd0, pd1, frame_cnt,
                     exp_v0, exp_v1, exp_pd0, exp_pd1, exp_cnt);
         end
         vectors++;
         if (valid_seen !== exp_valid || err_seen !== exp_err) begin
            miscompares++;
            $display("FAIL random_pulses_%0d: got valid=%0d err=%0d, want %0d %0d",
                     k, valid_seen, err_seen, exp_valid, exp_err);
         end
      end
   endtask

   task automatic test_exclusive();
      vectors++;
      if (both_seen !== 0) begin
         miscompares++;
         $display("FAIL exclusive: got %0d cycles with valid and frame_err, want 0",
                  both_seen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pd();
      test_abort();
      test_overrun();
      test_simultaneous();
      test_reset_midframe();
      // Realign pulse expectations after the reset wiped the model.
      exp_valid = valid_seen;
      exp_err   = err_seen;
      test_back_to_back();
      test_random();
      test_exclusive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
